mc_ctrl: RTL
============

# mc_ctrl

Multi-cycle control sequencer for the MIPS core. Consumes the fields produced by the instruction decoder, steps each instruction through FETCH/DECODE/EXEC/MEM/WB, and drives every enable and mux select on the shared datapath (PC, IR, register file, ALU, single memory port). It also feeds `sign_ext_o` back to the decoder. It is the only block allowed to write PC, IR or the register file.

## Interface
- `MULDIV_CYCLES`, 32: EXEC stall length for mult/div, legal range 1..64.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `op_i` in 6: opcode from the decoder.
- `funct_i` in 6: funct field.
- `rt_i` in 5: rt field, used for REGIMM decode.
- `is_r_type_i` in 1: opcode is 0.
- `use_link_reg_i` in 1: instruction writes r31 or rd with PC+4 (jalr, bltzal, bgezal).
- `branch_taken_i` in 1: branch condition from the ALU/compare, valid in EXEC.
- `mem_ack_i` in 1: memory port completes the current request this cycle.
- `pc_we_o` out 1: PC write strobe.
- `pc_src_o` out 2: PC source. 0 = PC+4, 1 = branch target, 2 = jump target, 3 = rs.
- `ir_we_o` out 1: IR write strobe.
- `mem_req_o` out 1: memory request.
- `mem_we_o` out 1: memory write.
- `mem_addr_src_o` out 1: memory address source. 0 = PC, 1 = ALU result.
- `reg_we_o` out 1: register-file write strobe.
- `reg_dst_o` out 2: destination register. 0 = rt, 1 = rd, 2 = r31.
- `wb_src_o` out 2: write-back source. 0 = ALU, 1 = memory data, 2 = PC+4.
- `alu_src_b_o` out 1: ALU B operand. 0 = rt, 1 = immediate.
- `sign_ext_o` out 1: to decoder. 0 for op 0x0C–0x0E, 1 otherwise.
- `muldiv_start_o` out 1: one-cycle start pulse to the mult/div unit.
- `exc_o` out 1: reserved-instruction trap pulse.
- `state_o` out 3: current state, debug only.

## Operation
- States: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, MULDIV=6, TRAP=7.
- Outputs are combinational functions of state and inputs. Every output not listed for a state is 0.
- IDLE:
  - Entered only from reset. All outputs 0.
  - Goes to FETCH on the next edge.
- FETCH:
  - Drives mem_req=1, mem_addr_src=0.
  - Waits while mem_ack=0.
  - On ack, in the same cycle: ir_we=1, pc_we=1, pc_src=0. Then goes to DECODE.
- DECODE: classifies the instruction.
  - j (0x02): pc_we=1, pc_src=2, then FETCH.
  - jal (0x03): additionally reg_we=1, reg_dst=2, wb_src=2.
  - Every other legal instruction goes to EXEC.
  - Illegal instruction goes to TRAP.
- EXEC, R-type ALU: next state WB, with reg_dst=1, wb_src=0.
- EXEC, jr (0x08) / jalr (0x09):
  - pc_we=1, pc_src=3.
  - jalr also drives reg_we=1, reg_dst=1, wb_src=2.
  - Next state FETCH.
- EXEC, beq/bne (0x04/0x05) and REGIMM (0x01, rt ∈ {0x00, 0x01, 0x10, 0x11}):
  - pc_we=branch_taken_i, pc_src=1.
  - If use_link_reg_i: reg_we=1, reg_dst=2, wb_src=2, whether or not the branch is taken.
  - Next state FETCH.
- EXEC, I-type ALU (0x08–0x0F): alu_src_b=1, next state WB with reg_dst=0, wb_src=0.
- EXEC, lw (0x23) / sw (0x2B): alu_src_b=1, next state MEM.
- MEM:
  - Drives mem_req=1, mem_addr_src=1, alu_src_b=1.
  - mem_we=1 for sw.
  - Waits for ack. On ack: sw goes to FETCH, lw goes to WB with reg_dst=0, wb_src=1.
- WB: reg_we=1 for exactly one cycle with the selects latched on entry, then FETCH.
- TRAP: exc_o=1 for one cycle, then FETCH. PC is not modified.
- While mem_req=1, mem_we and mem_addr_src are held constant until ack. mem_ack_i is ignored when mem_req=0.
- Reset asserted mid-instruction goes to IDLE immediately. All outputs fall to 0 asynchronously, and any pending request is dropped.

## Timing
- Zero-wait memory: ack may arrive in the same cycle as the request.
- Cycles per instruction, with zero-wait memory:
  - j/jal: 2.
  - Branch, jr, jalr: 3.
  - ALU ops and sw: 4.
  - lw: 5.
  - Each memory wait cycle adds 1.
- First FETCH occurs 1 cycle after rst_n deasserts, because of the IDLE cycle.
- Strobes (pc_we, ir_we, reg_we, exc_o, muldiv_start) never last more than one cycle per state visit.

## Configuration
- `MC_CTRL_MULDIV_EN` defined:
  - R-type funct 0x18–0x1B is legal.
  - EXEC drives muldiv_start=1, then enters MULDIV.
  - A 6-bit down-counter loaded with MULDIV_CYCLES-1 holds MULDIV until it reaches 0, then goes to FETCH. No reg_we.
  - MULDIV_CYCLES=1 leaves MULDIV after one cycle.
- Undefined: those functs are illegal and go to TRAP. The MULDIV state and counter are absent; state 6 is unreachable and muldiv_start_o is tied to 0.

## Test plan
- Reset, then addu with zero-wait memory → state sequence 0,1,2,3,5,1. ir_we and pc_we in cycle 1. reg_we=1, reg_dst=1 in cycle 4.
- lw with mem_ack delayed 2 cycles in both FETCH and MEM → mem_req held for 3 cycles each phase. mem_addr_src 0 then 1. WB has wb_src=1. Total 9 cycles.
- bltzal not taken (op 0x01, rt 0x10, branch_taken=0) → EXEC has pc_we=0, reg_we=1, reg_dst=2, wb_src=2.
- Illegal op 0x3F → exc_o=1 for exactly one cycle in TRAP, no pc_we, then FETCH.
- With `MC_CTRL_MULDIV_EN` and MULDIV_CYCLES=4, issue mult (funct 0x18) → one muldiv_start pulse, 4 MULDIV cycles, then FETCH. Without the macro, the same instruction goes to TRAP.
- rst_n driven low during MEM of sw with mem_req=1 → mem_req and mem_we go to 0 immediately, state_o=0. After release, FETCH follows one cycle later.

Source files
------------

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle control sequencer for the MIPS core.
//
// Steps each instruction through FETCH/DECODE/EXEC/MEM/WB and drives every
// enable and mux select on the shared datapath (PC, IR, register file, ALU,
// single memory port). Outputs are combinational in state and inputs; the
// write-back selects are latched on entry to WB.
//
// Optional feature: define MC_CTRL_MULDIV_EN to accept mult/div (R-type
// funct 0x18-0x1B), which stall in the MULDIV state for MULDIV_CYCLES cycles.
// Without it those functs trap and muldiv_start_o is tied to 0.
//
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   op_i/funct_i/rt_i     instruction fields from the decoder
//   is_r_type_i           opcode is 0
//   use_link_reg_i        instruction writes a link register with PC+4
//   branch_taken_i        branch condition, valid in EXEC
//   mem_ack_i             memory port completes the request this cycle
//   pc_we_o, pc_src_o     PC write strobe / source (0 PC+4, 1 br, 2 jmp, 3 rs)
//   ir_we_o               IR write strobe
//   mem_req_o, mem_we_o   memory request / write
//   mem_addr_src_o        memory address (0 PC, 1 ALU)
//   reg_we_o, reg_dst_o   regfile write strobe / destination (0 rt, 1 rd, 2 r31)
//   wb_src_o              write-back source (0 ALU, 1 mem, 2 PC+4)
//   alu_src_b_o           ALU B operand (0 rt, 1 imm)
//   sign_ext_o            immediate extension mode back to the decoder
//   muldiv_start_o        one-cycle start pulse to the mult/div unit
//   exc_o                 reserved-instruction trap pulse
//   state_o               current state, debug only
module mc_ctrl #(
  parameter int unsigned MULDIV_CYCLES = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op_i,
  input  logic [5:0] funct_i,
  input  logic [4:0] rt_i,
  input  logic       is_r_type_i,
  input  logic       use_link_reg_i,
  input  logic       branch_taken_i,
  input  logic       mem_ack_i,
  output logic       pc_we_o,
  output logic [1:0] pc_src_o,
  output logic       ir_we_o,
  output logic       mem_req_o,
  output logic       mem_we_o,
  output logic       mem_addr_src_o,
  output logic       reg_we_o,
  output logic [1:0] reg_dst_o,
  output logic [1:0] wb_src_o,
  output logic       alu_src_b_o,
  output logic       sign_ext_o,
  output logic       muldiv_start_o,
  output logic       exc_o,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StFetch  = 3'd1,
    StDecode = 3'd2,
    StExec   = 3'd3,
    StMem    = 3'd4,
    StWb     = 3'd5,
    StMuldiv = 3'd6,
    StTrap   = 3'd7
  } state_e;

  localparam logic [5:0] MuldivLoad = 6'(MULDIV_CYCLES - 1);

  state_e     state_q, state_d;
  logic       store_q, store_d;       // MEM phase is a store
  logic [1:0] wb_dst_q, wb_dst_d;     // reg_dst captured for WB
  logic [1:0] wb_src_q, wb_src_d;     // wb_src captured for WB

  // Instruction classification
  logic dec_j, dec_jal, dec_jr, dec_jalr, dec_r_alu, dec_muldiv;
  logic dec_branch, dec_i_alu, dec_lw, dec_sw, dec_legal;

  assign dec_j     = !is_r_type_i && (op_i == 6'h02);
  assign dec_jal   = !is_r_type_i && (op_i == 6'h03);
  assign dec_jr    = is_r_type_i && (funct_i == 6'h08);
  assign dec_jalr  = is_r_type_i && (funct_i == 6'h09);
  assign dec_r_alu = is_r_type_i &&
                     (funct_i inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
                                      [6'h10:6'h13], [6'h20:6'h27], 6'h2A, 6'h2B});
  assign dec_branch = !is_r_type_i &&
                      ((op_i inside {6'h04, 6'h05}) ||
                       ((op_i == 6'h01) && (rt_i inside {5'h00, 5'h01, 5'h10, 5'h11})));
  assign dec_i_alu = !is_r_type_i && (op_i[5:3] == 3'b001);
  assign dec_lw    = !is_r_type_i && (op_i == 6'h23);
  assign dec_sw    = !is_r_type_i && (op_i == 6'h2B);

`ifdef MC_CTRL_MULDIV_EN
  assign dec_muldiv = is_r_type_i && (funct_i inside {[6'h18:6'h1B]});
`else
  assign dec_muldiv = 1'b0;
`endif

  assign dec_legal = dec_j | dec_jal | dec_jr | dec_jalr | dec_r_alu | dec_muldiv |
                     dec_branch | dec_i_alu | dec_lw | dec_sw;

`ifdef MC_CTRL_MULDIV_EN
  logic [5:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^MuldivLoad;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      store_q  <= 1'b0;
      wb_dst_q <= 2'd0;
      wb_src_q <= 2'd0;
    end else begin
      state_q  <= state_d;
      store_q  <= store_d;
      wb_dst_q <= wb_dst_d;
      wb_src_q <= wb_src_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    store_d        = store_q;
    wb_dst_d       = wb_dst_q;
    wb_src_d       = wb_src_q;
`ifdef MC_CTRL_MULDIV_EN
    cnt_d          = cnt_q;
`endif
    pc_we_o        = 1'b0;
    pc_src_o       = 2'd0;
    ir_we_o        = 1'b0;
    mem_req_o      = 1'b0;
    mem_we_o       = 1'b0;
    mem_addr_src_o = 1'b0;
    reg_we_o       = 1'b0;
    reg_dst_o      = 2'd0;
    wb_src_o       = 2'd0;
    alu_src_b_o    = 1'b0;
    muldiv_start_o = 1'b0;
    exc_o          = 1'b0;

    unique case (state_q)
      StIdle: state_d = StFetch;

      StFetch: begin
        mem_req_o = 1'b1;
        if (mem_ack_i) begin
          ir_we_o = 1'b1;
          pc_we_o = 1'b1;
          state_d = StDecode;
        end
      end

      StDecode: begin
        if (dec_j || dec_jal) begin
          pc_we_o  = 1'b1;
          pc_src_o = 2'd2;
          if (dec_jal) begin
            reg_we_o  = 1'b1;
            reg_dst_o = 2'd2;
            wb_src_o  = 2'd2;
          end
          state_d = StFetch;
        end else if (dec_legal) begin
          state_d = StExec;
        end else begin
          state_d = StTrap;
        end
      end

      StExec: begin
        if (dec_jr || dec_jalr) begin
          pc_we_o  = 1'b1;
          pc_src_o = 2'd3;
          if (dec_jalr) begin
            reg_we_o  = 1'b1;
            reg_dst_o = 2'd1;
            wb_src_o  = 2'd2;
          end
          state_d = StFetch;
        end else if (dec_branch) begin
          pc_we_o  = branch_taken_i;
          pc_src_o = 2'd1;
          // Link is written whether or not the branch is taken
          if (use_link_reg_i) begin
            reg_we_o  = 1'b1;
            reg_dst_o = 2'd2;
            wb_src_o  = 2'd2;
          end
          state_d = StFetch;
`ifdef MC_CTRL_MULDIV_EN
        end else if (dec_muldiv) begin
          muldiv_start_o = 1'b1;
          cnt_d          = MuldivLoad;
          state_d        = StMuldiv;
`endif
        end else if (dec_r_alu) begin
          wb_dst_d = 2'd1;
          wb_src_d = 2'd0;
          state_d  = StWb;
        end else if (dec_i_alu) begin
          alu_src_b_o = 1'b1;
          wb_dst_d    = 2'd0;
          wb_src_d    = 2'd0;
          state_d     = StWb;
        end else if (dec_lw || dec_sw) begin
          alu_src_b_o = 1'b1;
          store_d     = dec_sw;
          state_d     = StMem;
        end else begin
          // Decoder fields changed under us; treat as illegal
          state_d = StTrap;
        end
      end

      StMem: begin
        // Selects depend only on state and store_q, so they hold until ack
        mem_req_o      = 1'b1;
        mem_addr_src_o = 1'b1;
        alu_src_b_o    = 1'b1;
        mem_we_o       = store_q;
        if (mem_ack_i) begin
          if (store_q) begin
            state_d = StFetch;
          end else begin
            wb_dst_d = 2'd0;
            wb_src_d = 2'd1;
            state_d  = StWb;
          end
        end
      end

      StWb: begin
        reg_we_o  = 1'b1;
        reg_dst_o = wb_dst_q;
        wb_src_o  = wb_src_q;
        state_d   = StFetch;
      end

      StMuldiv: begin
`ifdef MC_CTRL_MULDIV_EN
        if (cnt_q == 6'd0) begin
          state_d = StFetch;
        end else begin
          cnt_d = cnt_q - 6'd1;
        end
`else
        state_d = StFetch;
`endif
      end

      StTrap: begin
        exc_o   = 1'b1;
        state_d = StFetch;
      end

      default: state_d = StIdle;
    endcase
  end

  assign sign_ext_o = (state_q != StIdle) && !(op_i inside {[6'h0C:6'h0E]});
  assign state_o    = state_q;

endmodule
